// File: rtl/math_divider_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding.
package math_divider_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/math_divider_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not go negative.
module math_divider_step
    import math_divider_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] rem_i,
    input  logic         q_msb_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted_s;
    logic [W:0] diff_s;

    // Guard bit keeps the shifted remainder exact before the trial subtraction
    always_comb begin
        shifted_s = {rem_i, q_msb_i};
        diff_s    = shifted_s - {1'b0, divisor_i};
        if (shifted_s >= {1'b0, divisor_i}) begin
            rem_o   = diff_s[W-1:0];
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s[W-1:0];
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/math_divider_restoring_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define MATH_DIVIDER_SIGNED_EN for two's-complement operands (truncation toward zero).
module math_divider_restoring_seq
    import math_divider_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_quotient,
    output logic [DATA_WIDTH-1:0] o_remainder,
    output logic                  o_div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  div_q, div_d;
    logic          dbz_q, dbz_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          odbz_q, odbz_d;
    logic [W-1:0]  oquo_q, oquo_d;
    logic [W-1:0]  orem_q, orem_d;

    logic [W-1:0]  step_rem_s;
    logic          step_bit_s;
    logic [W-1:0]  fin_quo_s;
    logic [W-1:0]  acc_dvd_s, acc_dvs_s;
    logic [W-1:0]  res_quo_s, res_rem_s;

    math_divider_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .q_msb_i   (quo_q[W-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem_s),
        .q_bit_o   (step_bit_s)
    );

    assign fin_quo_s = {quo_q[W-2:0], step_bit_s};

`ifdef MATH_DIVIDER_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    function automatic logic [W-1:0] twos_neg(input logic [W-1:0] v);
        return (~v) + {{(W-1){1'b0}}, 1'b1};
    endfunction

    assign acc_dvd_s = i_dividend[W-1] ? twos_neg(i_dividend) : i_dividend;
    assign acc_dvs_s = i_divisor[W-1]  ? twos_neg(i_divisor)  : i_divisor;
    // A zero divisor already yields remainder = |dividend|; re-signing restores the dividend
    assign res_quo_s = dbz_q  ? {W{1'b1}} : (negq_q ? twos_neg(fin_quo_s) : fin_quo_s);
    assign res_rem_s = negr_q ? twos_neg(step_rem_s) : step_rem_s;

    // Result sign flags captured at acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    // Sign flags load only on operand acceptance
    always_comb begin
        negq_d = negq_q;
        negr_d = negr_q;
        if (state_q == IDLE && i_valid && ready_q) begin
            negq_d = i_dividend[W-1] ^ i_divisor[W-1];
            negr_d = i_dividend[W-1];
        end else begin
            negq_d = negq_q;
            negr_d = negr_q;
        end
    end
`else
    assign acc_dvd_s = i_dividend;
    assign acc_dvs_s = i_divisor;
    assign res_quo_s = fin_quo_s;
    assign res_rem_s = step_rem_s;
`endif

    // State, datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {W{1'b0}};
            quo_q   <= {W{1'b0}};
            div_q   <= {W{1'b0}};
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            odbz_q  <= 1'b0;
            oquo_q  <= {W{1'b0}};
            orem_q  <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            odbz_q  <= odbz_d;
            oquo_q  <= oquo_d;
            orem_q  <= orem_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        dbz_d   = dbz_q;
        ready_d = ready_q;
        valid_d = valid_q;
        odbz_d  = odbz_q;
        oquo_d  = oquo_q;
        orem_d  = orem_q;
        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    state_d = BUSY;
                    quo_d   = acc_dvd_s;
                    rem_d   = {W{1'b0}};
                    div_d   = acc_dvs_s;
                    cnt_d   = CNT_LOAD;
                    dbz_d   = (i_divisor == {W{1'b0}});
                    ready_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                rem_d = step_rem_s;
                quo_d = fin_quo_s;
                cnt_d = cnt_q - CNT_ONE;
                // Final step: the shifted-in bit goes straight into the output registers
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    oquo_d  = res_quo_s;
                    orem_d  = res_rem_s;
                    odbz_d  = dbz_q;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    odbz_d  = 1'b0;
                    dbz_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                odbz_d  = 1'b0;
            end
        endcase
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_quotient    = oquo_q;
    assign o_remainder   = orem_q;
    assign o_div_by_zero = odbz_q;

endmodule

// File: tb/tb_math_divider_restoring_seq.sv
// Directed self-checking bench for math_divider_restoring_seq (8-bit), covering
// latency, boundaries, divide-by-zero, backpressure, mid-operation reset and signed mode.
module tb_math_divider_restoring_seq;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int tests;
    int failed;

    math_divider_restoring_seq #(.DATA_WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one division, check exact latency, the result, then consume it.
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        int early;
        early = 0;
        @(negedge i_clk);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid    = 1'b0;
        i_dividend = 8'h00;
        i_divisor  = 8'h00;
        for (int k = 0; k < W; k++) begin
            @(negedge i_clk);
            if (o_valid) early++;
            @(posedge i_clk);
        end
        check({tag, "_early_valid"}, 32'(early), 32'd0);
        @(negedge i_clk);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_quot"}, 32'(o_quotient), 32'(q));
        check({tag, "_rem"}, 32'(o_remainder), 32'(r));
        check({tag, "_dbz"}, 32'(o_div_by_zero), 32'(z));
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        check({tag, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
        check({tag, "_dbz_clear"}, 32'(o_div_by_zero), 32'd0);
        check({tag, "_quot_held"}, 32'(o_quotient), 32'(q));
    endtask

    initial begin
        int early;
        tests      = 0;
        failed     = 0;
        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_dividend = 8'h00;
        i_divisor  = 8'h00;

        #12;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_quot", 32'(o_quotient), 32'd0);
        check("rst_rem", 32'(o_remainder), 32'd0);
        check("rst_dbz", 32'(o_div_by_zero), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

`ifdef MATH_DIVIDER_SIGNED_EN
        do_div("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
        do_div("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
        do_div("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        do_div("s_m100_10", 8'h9C, 8'h0A, 8'hF6, 8'h00, 1'b0);
        do_div("s_dbz_neg", 8'hF3, 8'h00, 8'hFF, 8'hF3, 1'b1);
`else
        do_div("u_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        do_div("u_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        do_div("u_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        do_div("u_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
`endif
        do_div("dbz_13_0", 8'd13, 8'd0, 8'hFF, 8'd13, 1'b1);

        // Backpressure: 77/5 = 15 r 2, with ignored operand pulses while busy/done
        @(negedge i_clk);
        i_dividend = 8'd77;
        i_divisor  = 8'd5;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_dividend = 8'd1;
        i_divisor  = 8'd1;
        early = 0;
        for (int k = 0; k < W; k++) begin
            @(negedge i_clk);
            if (o_valid || o_ready) early++;
            i_valid = (k % 2 == 0);
            @(posedge i_clk);
        end
        check("bp_busy_flags", 32'(early), 32'd0);
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_quot", 32'(o_quotient), 32'd15);
            check("bp_rem", 32'(o_remainder), 32'd2);
            @(posedge i_clk);
        end
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        check("bp_released", 32'(o_valid), 32'd0);
        do_div("bp_100_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0);

        // Reset in the middle of BUSY aborts; a previous result is cleared
        @(negedge i_clk);
        i_dividend = 8'd50;
        i_divisor  = 8'd3;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_quot", 32'(o_quotient), 32'd0);
        check("mid_rst_rem", 32'(o_remainder), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        early = 0;
        repeat (W + 2) begin
            @(negedge i_clk);
            if (o_valid) early++;
        end
        check("mid_rst_no_result", 32'(early), 32'd0);
        do_div("post_rst_9_2", 8'd9, 8'd2, 8'd4, 8'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
